// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
//
// Instruction-fetch stage. Owns the PC, issues word fetches to instruction
// memory over a valid/ready request channel, matches in-order responses
// against a 2-entry tracker of issued PCs, and buffers the results in a
// 2-entry FIFO that feeds decode with valid/ready.
//
// A taken branch/jump from EX (redirect_i) reloads the PC, empties the output
// FIFO and marks every tracked request as wrong-path. Responses to those
// requests still arrive and are discarded.
//
// Requests are throttled by a credit rule: a new fetch may issue only while
// (outstanding requests + buffered instructions) < 2. Every response
// therefore has a FIFO slot waiting for it, and the memory response channel
// needs no backpressure.
//
// Ports
//   clk_i            in   1   clock
//   rst_i            in   1   synchronous active-high reset
//   redirect_i       in   1   taken branch/jump pulse from EX
//   redirect_pc_i    in  32   redirect target (forced to word alignment)
//   imem_req_valid_o out  1   fetch request valid
//   imem_req_ready_i in   1   memory accepts request
//   imem_req_addr_o  out 32   fetch address (word aligned)
//   imem_rsp_valid_i in   1   response valid, in request order
//   imem_rsp_data_i  in  32   fetched instruction
//   inst_valid_o     out  1   instruction available to decode
//   inst_ready_i     in   1   decode accepts
//   inst_o           out 32   instruction
//   inst_pc_o        out 32   PC of inst_o
// ---------------------------------------------------------------------------
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_valid_o,
    input  logic        imem_req_ready_i,
    output logic [31:0] imem_req_addr_o,
    input  logic        imem_rsp_valid_i,
    input  logic [31:0] imem_rsp_data_i,
    output logic        inst_valid_o,
    input  logic        inst_ready_i,
    output logic [31:0] inst_o,
    output logic [31:0] inst_pc_o
);

    // Program counter of the next request.
    logic [31:0] pc_r;

    // In-order tracker of issued requests: PC plus a live bit that is
    // cleared when a redirect makes the request wrong-path.
    logic [31:0] trk_pc [2];
    logic [1:0]  trk_live;
    logic        trk_wr;
    logic        trk_rd;
    logic [1:0]  trk_count;

    // Output FIFO of {instruction, PC} pairs.
    logic [31:0] fifo_inst [2];
    logic [31:0] fifo_pc   [2];
    logic        fifo_wr;
    logic        fifo_rd;
    logic [1:0]  fifo_count;

    logic        credit_ok;
    logic        req_fire;
    logic        rsp_pop;
    logic        fifo_push;
    logic        fifo_pop;

    // The two low target bits are dropped by word alignment.
    logic        unused_pc_bits;
    assign unused_pc_bits = ^redirect_pc_i[1:0];

    // -----------------------------------------------------------------------
    // Handshake decode
    // -----------------------------------------------------------------------
    assign credit_ok        = ({1'b0, trk_count} + {1'b0, fifo_count}) < 3'd2;
    assign imem_req_valid_o = ~rst_i & credit_ok;
    assign imem_req_addr_o  = pc_r;
    assign req_fire         = imem_req_valid_o & imem_req_ready_i;

    // A response with nothing tracked is a leftover from before reset: drop.
    assign rsp_pop   = imem_rsp_valid_i & (trk_count != 2'd0);
    // Wrong-path responses, and anything arriving alongside a redirect,
    // are consumed from the tracker but never buffered.
    assign fifo_push = rsp_pop & trk_live[trk_rd] & ~redirect_i;

    assign inst_valid_o = ~rst_i & (fifo_count != 2'd0);
    assign fifo_pop     = inst_valid_o & inst_ready_i;
    assign inst_o       = fifo_inst[fifo_rd];
    assign inst_pc_o    = fifo_pc[fifo_rd];

    // -----------------------------------------------------------------------
    // PC, tracker control and output FIFO
    // -----------------------------------------------------------------------
    // NOTE: sequential state is updated with non-blocking assignments only,
    // so every register samples the pre-edge value of every other register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc_r       <= {RESET_PC[31:2], 2'b00};
            trk_live   <= 2'b00;
            trk_wr     <= 1'b0;
            trk_rd     <= 1'b0;
            trk_count  <= 2'd0;
            fifo_wr    <= 1'b0;
            fifo_rd    <= 1'b0;
            fifo_count <= 2'd0;
            // NOTE: the FIFO storage is reset because inst_o/inst_pc_o read
            // it directly and must show zero out of reset; the tracker PC
            // storage is never observed while empty and is left unreset.
            fifo_inst[0] <= 32'd0;
            fifo_inst[1] <= 32'd0;
            fifo_pc[0]   <= 32'd0;
            fifo_pc[1]   <= 32'd0;
        end else begin
            // PC: redirect wins over the sequential increment.
            if (redirect_i) begin
                pc_r <= {redirect_pc_i[31:2], 2'b00};
            end else if (req_fire) begin
                pc_r <= pc_r + 32'd4;
            end

            // Tracker pointers and occupancy. The credit rule keeps a push
            // from ever landing on a full tracker.
            if (req_fire) begin
                trk_wr <= ~trk_wr;
            end
            if (rsp_pop) begin
                trk_rd <= ~trk_rd;
            end
            trk_count <= trk_count + {1'b0, req_fire} - {1'b0, rsp_pop};

            // A redirect kills everything tracked, including a same-cycle push.
            if (redirect_i) begin
                trk_live <= 2'b00;
            end else if (req_fire) begin
                trk_live[trk_wr] <= 1'b1;
            end

            // Output FIFO: a redirect flushes it and overrides any
            // same-cycle push or pop.
            if (redirect_i) begin
                fifo_wr    <= 1'b0;
                fifo_rd    <= 1'b0;
                fifo_count <= 2'd0;
            end else begin
                if (fifo_push) begin
                    fifo_inst[fifo_wr] <= imem_rsp_data_i;
                    fifo_pc[fifo_wr]   <= trk_pc[trk_rd];
                    fifo_wr            <= ~fifo_wr;
                end
                if (fifo_pop) begin
                    fifo_rd <= ~fifo_rd;
                end
                fifo_count <= fifo_count + {1'b0, fifo_push} - {1'b0, fifo_pop};
            end
        end
    end

    // Tracker PC storage: written on every accepted request, read only
    // through valid tracker entries.
    always_ff @(posedge clk_i) begin
        if (req_fire) begin
            trk_pc[trk_wr] <= pc_r;
        end
    end

endmodule
